// File: rtl/smpu_pkg.sv
// Shared AHB-Lite encodings, gate FSM states and violation record layout for the SMPU access gate.
package smpu_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned HTRANS_W = 2;
    localparam int unsigned HRESP_W  = 2;
    localparam int unsigned HSIZE_W  = 3;
    localparam int unsigned HPROT_W  = 4;
    localparam int unsigned INFO_W   = 8;

    localparam logic [HTRANS_W-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [HTRANS_W-1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [HTRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [HTRANS_W-1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [HRESP_W-1:0] HRESP_OKAY  = 2'b00;
    localparam logic [HRESP_W-1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } gate_state_e;

    // Layout of viol_info as seen by software.
    typedef struct packed {
        logic       valid;
        logic       hwrite;
        logic [2:0] hsize;
        logic [2:0] hprot;
    } viol_info_t;

endpackage

// File: rtl/smpu_viol_log.sv
// Violation log: first-violation capture, saturating deny counter, software clear and level irq.
module smpu_viol_log
    import smpu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                viol_hit,
    input  logic [ADDR_W-1:0]   haddr,
    input  logic                hwrite,
    input  logic [HSIZE_W-1:0]  hsize,
    input  logic [2:0]          hprot,
    input  logic                log_clr,
    input  logic                irq_en,
    output logic [ADDR_W-1:0]   viol_addr,
    output logic [INFO_W-1:0]   viol_info,
    output logic [CNT_W-1:0]    viol_cnt,
    output logic                smpu_irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ADDR_W-1:0] addr_q;
    viol_info_t        info_q;
    logic [CNT_W-1:0]  cnt_q;

    // A violation landing in the same cycle as a clear wins and restarts the log.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            addr_q <= '0;
            info_q <= '0;
            cnt_q  <= '0;
        end else if (viol_hit) begin
            if (log_clr) begin
                cnt_q <= CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (log_clr || !info_q.valid) begin
                addr_q        <= haddr;
                info_q.valid  <= 1'b1;
                info_q.hwrite <= hwrite;
                info_q.hsize  <= hsize;
                info_q.hprot  <= hprot;
            end
        end else if (log_clr) begin
            addr_q <= '0;
            info_q <= '0;
            cnt_q  <= '0;
        end
    end

    assign viol_addr = addr_q;
    assign viol_info = info_q;
    assign viol_cnt  = cnt_q;
    assign smpu_irq  = info_q.valid & irq_en;

endmodule

// File: rtl/smpu_ahb_gate.sv
// SMPU access gate between CPU BIU and system bus: forwards permitted transfers with no added
// latency and answers denied ones with a locally generated two-cycle AHB ERROR response.
module smpu_ahb_gate
    import smpu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic [1:0]           biu_pad_htrans,
    input  logic [31:0]          biu_pad_haddr,
    input  logic [3:0]           biu_pad_hprot,
    input  logic                 biu_pad_hwrite,
    input  logic [2:0]           biu_pad_hsize,
    input  logic [31:0]          biu_pad_hwdata,
    output logic                 pad_biu_hready,
    output logic [1:0]           pad_biu_hresp,
    output logic [31:0]          pad_biu_hrdata,
    input  logic                 smpu_deny,
    output logic [1:0]           gate_pad_htrans,
    output logic [31:0]          gate_pad_haddr,
    output logic [3:0]           gate_pad_hprot,
    output logic                 gate_pad_hwrite,
    output logic [2:0]           gate_pad_hsize,
    output logic [31:0]          gate_pad_hwdata,
    input  logic                 pad_gate_hready,
    input  logic [1:0]           pad_gate_hresp,
    input  logic [31:0]          pad_gate_hrdata,
    input  logic                 log_clr,
    input  logic                 irq_en,
    output logic [31:0]          viol_addr,
    output logic [7:0]           viol_info,
    output logic [CNT_W-1:0]     viol_cnt,
    output logic                 smpu_irq
);

    gate_state_e state;
    logic        deny_req;
    logic        viol_hit;

    assign deny_req = biu_pad_htrans[1] & smpu_deny;

    // A denied address phase is accepted by the bus in PASS only when hready is high; in ERR2
    // the CPU itself sees hready=1, so the presented phase is always accepted there.
    assign viol_hit = deny_req & (((state == ST_PASS) & pad_gate_hready) | (state == ST_ERR2));

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state <= ST_PASS;
        end else begin
            case (state)
                ST_PASS: if (viol_hit) state <= ST_ERR1;
                ST_ERR1: state <= ST_ERR2;
                ST_ERR2: state <= viol_hit ? ST_ERR1 : ST_PASS;
                default: state <= ST_PASS;
            endcase
        end
    end

    // CPU response and bus htrans mux; the bus data phase behind a denied address is idle.
    always_comb begin
        pad_biu_hready  = pad_gate_hready;
        pad_biu_hresp   = pad_gate_hresp;
        pad_biu_hrdata  = pad_gate_hrdata;
        gate_pad_htrans = deny_req ? HTRANS_IDLE : biu_pad_htrans;
        case (state)
            ST_ERR1: begin
                pad_biu_hready  = 1'b0;
                pad_biu_hresp   = HRESP_ERROR;
                pad_biu_hrdata  = '0;
                gate_pad_htrans = HTRANS_IDLE;
            end
            ST_ERR2: begin
                pad_biu_hready = 1'b1;
                pad_biu_hresp  = HRESP_ERROR;
                pad_biu_hrdata = '0;
            end
            default: ;
        endcase
    end

    assign gate_pad_haddr  = biu_pad_haddr;
    assign gate_pad_hprot  = biu_pad_hprot;
    assign gate_pad_hwrite = biu_pad_hwrite;
    assign gate_pad_hsize  = biu_pad_hsize;
    assign gate_pad_hwdata = biu_pad_hwdata;

    smpu_viol_log #(
        .CNT_W (CNT_W)
    ) u_viol_log (
        .pclk      (pclk),
        .presetn   (presetn),
        .viol_hit  (viol_hit),
        .haddr     (biu_pad_haddr),
        .hwrite    (biu_pad_hwrite),
        .hsize     (biu_pad_hsize),
        .hprot     (biu_pad_hprot[2:0]),
        .log_clr   (log_clr),
        .irq_en    (irq_en),
        .viol_addr (viol_addr),
        .viol_info (viol_info),
        .viol_cnt  (viol_cnt),
        .smpu_irq  (smpu_irq)
    );

endmodule

// File: tb/tb_smpu_ahb_gate.sv
// Self-checking bench for smpu_ahb_gate: per-cycle CPU/bus response expectations queued as
// stimulus is driven and compared mid-cycle, plus direct checks of the violation log.
module tb_smpu_ahb_gate;
    import smpu_pkg::*;

    localparam int unsigned CNT_W = 8;

    logic             pclk;
    logic             presetn;
    logic [1:0]       biu_pad_htrans;
    logic [31:0]      biu_pad_haddr;
    logic [3:0]       biu_pad_hprot;
    logic             biu_pad_hwrite;
    logic [2:0]       biu_pad_hsize;
    logic [31:0]      biu_pad_hwdata;
    logic             pad_biu_hready;
    logic [1:0]       pad_biu_hresp;
    logic [31:0]      pad_biu_hrdata;
    logic             smpu_deny;
    logic [1:0]       gate_pad_htrans;
    logic [31:0]      gate_pad_haddr;
    logic [3:0]       gate_pad_hprot;
    logic             gate_pad_hwrite;
    logic [2:0]       gate_pad_hsize;
    logic [31:0]      gate_pad_hwdata;
    logic             pad_gate_hready;
    logic [1:0]       pad_gate_hresp;
    logic [31:0]      pad_gate_hrdata;
    logic             log_clr;
    logic             irq_en;
    logic [31:0]      viol_addr;
    logic [7:0]       viol_info;
    logic [CNT_W-1:0] viol_cnt;
    logic             smpu_irq;

    smpu_ahb_gate #(.CNT_W(CNT_W)) dut (
        .pclk            (pclk),
        .presetn         (presetn),
        .biu_pad_htrans  (biu_pad_htrans),
        .biu_pad_haddr   (biu_pad_haddr),
        .biu_pad_hprot   (biu_pad_hprot),
        .biu_pad_hwrite  (biu_pad_hwrite),
        .biu_pad_hsize   (biu_pad_hsize),
        .biu_pad_hwdata  (biu_pad_hwdata),
        .pad_biu_hready  (pad_biu_hready),
        .pad_biu_hresp   (pad_biu_hresp),
        .pad_biu_hrdata  (pad_biu_hrdata),
        .smpu_deny       (smpu_deny),
        .gate_pad_htrans (gate_pad_htrans),
        .gate_pad_haddr  (gate_pad_haddr),
        .gate_pad_hprot  (gate_pad_hprot),
        .gate_pad_hwrite (gate_pad_hwrite),
        .gate_pad_hsize  (gate_pad_hsize),
        .gate_pad_hwdata (gate_pad_hwdata),
        .pad_gate_hready (pad_gate_hready),
        .pad_gate_hresp  (pad_gate_hresp),
        .pad_gate_hrdata (pad_gate_hrdata),
        .log_clr         (log_clr),
        .irq_en          (irq_en),
        .viol_addr       (viol_addr),
        .viol_info       (viol_info),
        .viol_cnt        (viol_cnt),
        .smpu_irq        (smpu_irq)
    );

    typedef struct {
        string       tag;
        logic        hready;
        logic [1:0]  hresp;
        logic [31:0] hrdata;
        logic [1:0]  gtrans;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic hready, input logic [1:0] hresp,
                              input logic [31:0] hrdata, input logic [1:0] gtrans);
        exp_t e;
        e.tag    = tag;
        e.hready = hready;
        e.hresp  = hresp;
        e.hrdata = hrdata;
        e.gtrans = gtrans;
        sb.push_back(e);
    endtask

    // Outputs are sampled mid-cycle, well away from the active edge.
    always @(negedge pclk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val({e.tag, ".hready"}, 32'(pad_biu_hready), 32'(e.hready));
            check_val({e.tag, ".hresp"},  32'(pad_biu_hresp),  32'(e.hresp));
            check_val({e.tag, ".hrdata"}, pad_biu_hrdata,      e.hrdata);
            check_val({e.tag, ".gtrans"}, 32'(gate_pad_htrans), 32'(e.gtrans));
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_cpu(input logic [1:0] htrans, input logic [31:0] addr, input logic wr,
                           input logic [2:0] size, input logic [3:0] prot, input logic deny);
        biu_pad_htrans = htrans;
        biu_pad_haddr  = addr;
        biu_pad_hwrite = wr;
        biu_pad_hsize  = size;
        biu_pad_hprot  = prot;
        smpu_deny      = deny;
    endtask

    task automatic cpu_idle();
        set_cpu(HTRANS_IDLE, 32'h0, 1'b0, 3'd0, 4'h0, 1'b0);
    endtask

    // n denied transfers starting from PASS, each following one presented in ERR2.
    task automatic deny_chain(input int n);
        for (int i = 0; i < n; i++) begin
            set_cpu(HTRANS_NONSEQ, 32'h7000_0000 + 32'(i * 4), 1'b1, 3'd2, 4'h3, 1'b1);
            expect_out("chain.addr", 1'b1, (i == 0) ? HRESP_OKAY : HRESP_ERROR, 32'h0, HTRANS_IDLE);
            tick();
            cpu_idle();
            expect_out("chain.err1", 1'b0, HRESP_ERROR, 32'h0, HTRANS_IDLE);
            tick();
        end
        cpu_idle();
        expect_out("chain.err2", 1'b1, HRESP_ERROR, 32'h0, HTRANS_IDLE);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        presetn         = 1'b0;
        cpu_idle();
        biu_pad_hwdata  = 32'h0;
        pad_gate_hready = 1'b1;
        pad_gate_hresp  = HRESP_OKAY;
        pad_gate_hrdata = 32'h0;
        log_clr         = 1'b0;
        irq_en          = 1'b1;
        tick();
        tick();
        presetn = 1'b1;

        // Reset state
        check_val("rst.hready", 32'(pad_biu_hready), 32'd1);
        check_val("rst.hresp",  32'(pad_biu_hresp),  32'(HRESP_OKAY));
        check_val("rst.cnt",    32'(viol_cnt),       32'd0);
        check_val("rst.info",   32'(viol_info),      32'h0);
        check_val("rst.addr",   viol_addr,           32'h0);
        check_val("rst.irq",    32'(smpu_irq),       32'd0);

        // 1: permitted read passes through with no added latency
        set_cpu(HTRANS_NONSEQ, 32'h2000_0000, 1'b0, 3'd2, 4'h3, 1'b0);
        biu_pad_hwdata = 32'h1357_9BDF;
        expect_out("t1.addr", 1'b1, HRESP_OKAY, 32'h0, HTRANS_NONSEQ);
        #1;
        check_val("t1.gaddr",  gate_pad_haddr,  32'h2000_0000);
        check_val("t1.ghwdata", gate_pad_hwdata, 32'h1357_9BDF);
        tick();
        cpu_idle();
        pad_gate_hready = 1'b0;
        expect_out("t1.wait", 1'b0, HRESP_OKAY, 32'h0, HTRANS_IDLE);
        tick();
        pad_gate_hready = 1'b1;
        pad_gate_hrdata = 32'hCAFE_F00D;
        expect_out("t1.data", 1'b1, HRESP_OKAY, 32'hCAFE_F00D, HTRANS_IDLE);
        tick();
        pad_gate_hrdata = 32'h0;
        check_val("t1.cnt", 32'(viol_cnt), 32'd0);

        // 2: denied write is blocked and answered with a two-cycle ERROR
        set_cpu(HTRANS_NONSEQ, 32'h4000_0010, 1'b1, 3'd2, 4'h3, 1'b1);
        expect_out("t2.addr", 1'b1, HRESP_OKAY, 32'h0, HTRANS_IDLE);
        #1;
        check_val("t2.gaddr",  gate_pad_haddr,         32'h4000_0010);
        check_val("t2.ghwrite", 32'(gate_pad_hwrite),  32'd1);
        tick();
        cpu_idle();
        pad_gate_hrdata = 32'hDEAD_BEEF;
        expect_out("t2.err1", 1'b0, HRESP_ERROR, 32'h0, HTRANS_IDLE);
        check_val("t2.vaddr", viol_addr,        32'h4000_0010);
        check_val("t2.vinfo", 32'(viol_info),   32'h0000_00D3);
        check_val("t2.cnt",   32'(viol_cnt),    32'd1);
        check_val("t2.irq",   32'(smpu_irq),    32'd1);
        irq_en = 1'b0;
        #1;
        check_val("t2.irq_off", 32'(smpu_irq), 32'd0);
        irq_en = 1'b1;
        tick();
        expect_out("t2.err2", 1'b1, HRESP_ERROR, 32'h0, HTRANS_IDLE);
        tick();
        pad_gate_hrdata = 32'h0;
        expect_out("t2.pass", 1'b1, HRESP_OKAY, 32'h0, HTRANS_IDLE);
        tick();

        // 3: later violations count but do not overwrite; deny in ERR2 re-enters ERR1
        set_cpu(HTRANS_NONSEQ, 32'h5000_0000, 1'b0, 3'd2, 4'h3, 1'b1);
        expect_out("t3.addr", 1'b1, HRESP_OKAY, 32'h0, HTRANS_IDLE);
        tick();
        cpu_idle();
        expect_out("t3.err1", 1'b0, HRESP_ERROR, 32'h0, HTRANS_IDLE);
        check_val("t3.cnt2",  32'(viol_cnt), 32'd2);
        check_val("t3.vaddr", viol_addr,     32'h4000_0010);
        tick();
        set_cpu(HTRANS_NONSEQ, 32'h5000_0100, 1'b0, 3'd2, 4'h3, 1'b1);
        expect_out("t3.err2deny", 1'b1, HRESP_ERROR, 32'h0, HTRANS_IDLE);
        tick();
        cpu_idle();
        expect_out("t3.reerr1", 1'b0, HRESP_ERROR, 32'h0, HTRANS_IDLE);
        check_val("t3.cnt3", 32'(viol_cnt), 32'd3);
        tick();
        set_cpu(HTRANS_NONSEQ, 32'h2000_0040, 1'b0, 3'd2, 4'h3, 1'b0);
        expect_out("t3.err2ok", 1'b1, HRESP_ERROR, 32'h0, HTRANS_NONSEQ);
        tick();
        cpu_idle();
        pad_gate_hrdata = 32'h1234_5678;
        expect_out("t3.data", 1'b1, HRESP_OKAY, 32'h1234_5678, HTRANS_IDLE);
        tick();
        pad_gate_hrdata = 32'h0;

        // 3b: denied phase stalled by bus hready is only logged once accepted
        set_cpu(HTRANS_NONSEQ, 32'h5000_0200, 1'b0, 3'd2, 4'h3, 1'b1);
        pad_gate_hready = 1'b0;
        expect_out("t3b.stall", 1'b0, HRESP_OKAY, 32'h0, HTRANS_IDLE);
        tick();
        check_val("t3b.cnt_stall", 32'(viol_cnt), 32'd3);
        pad_gate_hready = 1'b1;
        expect_out("t3b.accept", 1'b1, HRESP_OKAY, 32'h0, HTRANS_IDLE);
        tick();
        cpu_idle();
        expect_out("t3b.err1", 1'b0, HRESP_ERROR, 32'h0, HTRANS_IDLE);
        check_val("t3b.cnt4", 32'(viol_cnt), 32'd4);
        tick();
        expect_out("t3b.err2", 1'b1, HRESP_ERROR, 32'h0, HTRANS_IDLE);
        tick();

        // 4: counter saturates at 255
        deny_chain(251);
        check_val("t4.cnt255", 32'(viol_cnt), 32'd255);
        deny_chain(1);
        check_val("t4.cnt_sat", 32'(viol_cnt), 32'd255);
        check_val("t4.vaddr",   viol_addr,     32'h4000_0010);

        // 5: violation wins over a same-cycle clear; plain clear empties the log
        set_cpu(HTRANS_NONSEQ, 32'h6000_0004, 1'b0, 3'd0, 4'hA, 1'b1);
        log_clr = 1'b1;
        expect_out("t5.addr", 1'b1, HRESP_OKAY, 32'h0, HTRANS_IDLE);
        tick();
        log_clr = 1'b0;
        cpu_idle();
        expect_out("t5.err1", 1'b0, HRESP_ERROR, 32'h0, HTRANS_IDLE);
        check_val("t5.vaddr", viol_addr,      32'h6000_0004);
        check_val("t5.vinfo", 32'(viol_info), 32'h0000_0082);
        check_val("t5.cnt",   32'(viol_cnt),  32'd1);
        check_val("t5.irq",   32'(smpu_irq),  32'd1);
        tick();
        expect_out("t5.err2", 1'b1, HRESP_ERROR, 32'h0, HTRANS_IDLE);
        tick();
        log_clr = 1'b1;
        expect_out("t5.clr", 1'b1, HRESP_OKAY, 32'h0, HTRANS_IDLE);
        tick();
        log_clr = 1'b0;
        check_val("t5.clr_addr", viol_addr,      32'h0);
        check_val("t5.clr_info", 32'(viol_info), 32'h0);
        check_val("t5.clr_cnt",  32'(viol_cnt),  32'd0);
        check_val("t5.clr_irq",  32'(smpu_irq),  32'd0);

        // 6: reset during ERR1 returns to PASS and clears the log
        set_cpu(HTRANS_NONSEQ, 32'h4000_0020, 1'b1, 3'd2, 4'h3, 1'b1);
        expect_out("t6.addr", 1'b1, HRESP_OKAY, 32'h0, HTRANS_IDLE);
        tick();
        cpu_idle();
        presetn = 1'b0;
        expect_out("t6.err1", 1'b0, HRESP_ERROR, 32'h0, HTRANS_IDLE);
        check_val("t6.cnt", 32'(viol_cnt), 32'd1);
        tick();
        expect_out("t6.rst", 1'b1, HRESP_OKAY, 32'h0, HTRANS_IDLE);
        check_val("t6.rst_cnt",  32'(viol_cnt),  32'd0);
        check_val("t6.rst_info", 32'(viol_info), 32'h0);
        check_val("t6.rst_addr", viol_addr,      32'h0);
        check_val("t6.rst_irq",  32'(smpu_irq),  32'd0);
        tick();
        presetn = 1'b1;
        expect_out("t6.post", 1'b1, HRESP_OKAY, 32'h0, HTRANS_IDLE);
        tick();
        tick();

        check_val("sb.drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
